// File: rtl/wb_regfile_if.sv
// W-stage bundle into the write-back register file, plus decode read ports and retire count.
// Carries no state of its own; all outputs are produced by the slave side.
// No handshake: every field is qualified by RegWriteW/ValidW and is consumed each cycle.
interface wb_regfile_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
);
   // MEM/WB pipeline bundle
   logic [XLEN-1:0]  ReadDataW;
   logic [XLEN-1:0]  ALUResultW;
   logic [XLEN-1:0]  PC_PLUS4W;
   logic [4:0]       Reg_destW;
   logic             RegWriteW;
   logic [1:0]       ResultSrcW;
   logic             ValidW;

   // decode-stage read ports
   logic [4:0]       A1D;
   logic [4:0]       A2D;
   logic [XLEN-1:0]  RD1D;
   logic [XLEN-1:0]  RD2D;

   // forwarding value and retire count
   logic [XLEN-1:0]  ResultW;
   logic [CNT_W-1:0] InstRetW;

   modport master (
      output ReadDataW, ALUResultW, PC_PLUS4W, Reg_destW, RegWriteW, ResultSrcW, ValidW,
      output A1D, A2D,
      input  RD1D, RD2D, ResultW, InstRetW
   );

   modport slave (
      input  ReadDataW, ALUResultW, PC_PLUS4W, Reg_destW, RegWriteW, ResultSrcW, ValidW,
      input  A1D, A2D,
      output RD1D, RD2D, ResultW, InstRetW
   );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage: result select, 32-entry register file (x0 hardwired), two bypassed read ports, retire counter.
// Latency: ResultW/RD1D/RD2D combinational; register commit and InstRetW update one cycle after the W-stage inputs.
// No backpressure: a write or retire is taken every cycle it is presented; rst wins over both.
module wb_regfile #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
) (
   input logic          clk,
   input logic          rst,
   wb_regfile_if.slave  bus
);

   // Entry 0 is not stored at all; reads of x0 are forced to zero below.
   logic [XLEN-1:0]  regs [1:31];
   logic [XLEN-1:0]  result;
   logic [XLEN-1:0]  rd1;
   logic [XLEN-1:0]  rd2;
   logic             wr_en;
   logic [CNT_W-1:0] inst_ret_q;

   // Result select; the reserved encoding falls back to the ALU result.
   always_comb begin
      result = bus.ALUResultW;
      case (bus.ResultSrcW)
         2'b01:   result = bus.ReadDataW;
         2'b10:   result = bus.PC_PLUS4W;
         default: result = bus.ALUResultW;
      endcase
   end

   // A write to x0 is dropped here so neither storage nor bypass ever sees it.
   always_comb begin
      wr_en = bus.RegWriteW && (bus.Reg_destW != 5'd0);
   end

   // Storage update; reset clears every entry and overrides a same-cycle write.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[bus.Reg_destW] <= result;
      end
   end

   // Read port 1: x0 is zero, then write-first bypass, then stored value.
   always_comb begin
      rd1 = '0;
      if (bus.A1D == 5'd0) begin
         rd1 = '0;
      end else if (wr_en && (bus.Reg_destW == bus.A1D)) begin
         rd1 = result;
      end else begin
         rd1 = regs[bus.A1D];
      end
   end

   // Read port 2: same priority as port 1, fully independent address.
   always_comb begin
      rd2 = '0;
      if (bus.A2D == 5'd0) begin
         rd2 = '0;
      end else if (wr_en && (bus.Reg_destW == bus.A2D)) begin
         rd2 = result;
      end else begin
         rd2 = regs[bus.A2D];
      end
   end

   // Retire counter; free-running wrap, reset overrides a same-cycle increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         inst_ret_q <= '0;
      end else if (bus.ValidW) begin
         inst_ret_q <= inst_ret_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign bus.ResultW  = result;
   assign bus.RD1D     = rd1;
   assign bus.RD2D     = rd2;
   assign bus.InstRetW = inst_ret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vector table, hand-written corner sequences, randomized run vs reference model.
// A narrow-counter second instance exercises counter wrap in a few cycles.
// Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
module tb_wb_regfile;

   logic clk;
   logic rst;
   logic rst_s;

   wb_regfile_if #(.XLEN(32), .CNT_W(64)) bus ();
   wb_regfile_if #(.XLEN(32), .CNT_W(4))  bus_s ();

   wb_regfile #(.XLEN(32), .CNT_W(64)) dut   (.clk(clk), .rst(rst),   .bus(bus));
   wb_regfile #(.XLEN(32), .CNT_W(4))  dut_s (.clk(clk), .rst(rst_s), .bus(bus_s));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model: architectural register values and retired count
   logic [31:0] m_regs [32];
   logic [63:0] m_cnt;

   typedef struct {
      logic [1:0]  src;
      logic [31:0] alu;
      logic [31:0] rdat;
      logic [31:0] pc4;
      logic [4:0]  dest;
      logic        we;
      logic        vld;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [31:0] e_res;
      logic [31:0] e_rd1;
      logic [31:0] e_rd2;
   } vec_t;

   vec_t vt [9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] src, input logic [31:0] alu, input logic [31:0] rdat,
                        input logic [31:0] pc4, input logic [4:0] dest, input logic we,
                        input logic vld, input logic [4:0] a1, input logic [4:0] a2);
      bus.ResultSrcW = src;
      bus.ALUResultW = alu;
      bus.ReadDataW  = rdat;
      bus.PC_PLUS4W  = pc4;
      bus.Reg_destW  = dest;
      bus.RegWriteW  = we;
      bus.ValidW     = vld;
      bus.A1D        = a1;
      bus.A2D        = a2;
   endtask

   function automatic logic [31:0] m_result();
      if (bus.ResultSrcW == 2'd1) return bus.ReadDataW;
      if (bus.ResultSrcW == 2'd2) return bus.PC_PLUS4W;
      return bus.ALUResultW;
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (bus.RegWriteW && bus.Reg_destW == a) return m_result();
      return m_regs[a];
   endfunction

   // apply the architectural effect of the current inputs, then advance one clock
   task automatic commit();
      if (rst) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
         m_cnt = 64'd0;
      end else begin
         if (bus.RegWriteW && bus.Reg_destW != 5'd0) m_regs[bus.Reg_destW] = m_result();
         if (bus.ValidW) m_cnt = m_cnt + 64'd1;
      end
      @(posedge clk);
      #1;
   endtask

   // idle inputs, then sweep both ports across every address and expect zero
   task automatic check_all_zero(input string tag);
      drive(2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
      for (int a = 0; a < 32; a++) begin
         bus.A1D = 5'(a);
         bus.A2D = 5'(31 - a);
         #1;
         chk({tag, "_rd1"}, {32'd0, bus.RD1D}, 64'd0);
         chk({tag, "_rd2"}, {32'd0, bus.RD2D}, 64'd0);
      end
   endtask

   initial begin
      logic [63:0] base;
      logic [31:0] v;
      logic [4:0]  d;

      vt[0] = '{2'd0, 32'h11, 32'h22, 32'h33, 5'd1, 1'b1, 1'b1, 5'd1, 5'd0, 32'h11, 32'h11, 32'h0};
      vt[1] = '{2'd1, 32'h11, 32'h22, 32'h33, 5'd2, 1'b1, 1'b1, 5'd1, 5'd2, 32'h22, 32'h11, 32'h22};
      vt[2] = '{2'd2, 32'h11, 32'h22, 32'h33, 5'd3, 1'b1, 1'b1, 5'd2, 5'd3, 32'h33, 32'h22, 32'h33};
      vt[3] = '{2'd3, 32'h11, 32'h22, 32'h33, 5'd4, 1'b1, 1'b1, 5'd3, 5'd4, 32'h11, 32'h33, 32'h11};
      vt[4] = '{2'd0, 32'hFFFFFFFF, 32'h22, 32'h33, 5'd0, 1'b1, 1'b1, 5'd0, 5'd4, 32'hFFFFFFFF, 32'h0, 32'h11};
      vt[5] = '{2'd0, 32'h5, 32'h0, 32'h0, 5'd7, 1'b1, 1'b1, 5'd0, 5'd7, 32'h5, 32'h0, 32'h5};
      vt[6] = '{2'd0, 32'hA, 32'h0, 32'h0, 5'd7, 1'b0, 1'b1, 5'd7, 5'd7, 32'hA, 32'h5, 32'h5};
      vt[7] = '{2'd0, 32'hA, 32'h0, 32'h0, 5'd7, 1'b1, 1'b1, 5'd7, 5'd7, 32'hA, 32'hA, 32'hA};
      vt[8] = '{2'd0, 32'h0, 32'h0, 32'h0, 5'd7, 1'b0, 1'b1, 5'd7, 5'd0, 32'h0, 32'hA, 32'h0};

      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_cnt = 64'd0;

      bus_s.ResultSrcW = 2'd0;
      bus_s.ALUResultW = 32'd0;
      bus_s.ReadDataW  = 32'd0;
      bus_s.PC_PLUS4W  = 32'd0;
      bus_s.Reg_destW  = 5'd0;
      bus_s.RegWriteW  = 1'b0;
      bus_s.ValidW     = 1'b0;
      bus_s.A1D        = 5'd0;
      bus_s.A2D        = 5'd0;
      rst_s = 1'b1;

      // reset cycle carrying a write and a retire: bypass is live, storage is not written
      rst = 1'b1;
      drive(2'd0, 32'hDEADBEEF, 32'd0, 32'd0, 5'd5, 1'b1, 1'b1, 5'd5, 5'd5);
      #1;
      chk("rst_bypass_rd1", {32'd0, bus.RD1D}, 64'hDEADBEEF);
      commit();
      rst = 1'b0;
      rst_s = 1'b0;
      check_all_zero("reset");
      chk("reset_instret", bus.InstRetW, 64'd0);

      // directed vector table
      for (int i = 0; i < 9; i++) begin
         drive(vt[i].src, vt[i].alu, vt[i].rdat, vt[i].pc4, vt[i].dest, vt[i].we, vt[i].vld,
               vt[i].a1, vt[i].a2);
         #1;
         chk($sformatf("vec%0d_res", i), {32'd0, bus.ResultW}, {32'd0, vt[i].e_res});
         chk($sformatf("vec%0d_rd1", i), {32'd0, bus.RD1D},    {32'd0, vt[i].e_rd1});
         chk($sformatf("vec%0d_rd2", i), {32'd0, bus.RD2D},    {32'd0, vt[i].e_rd2});
         commit();
      end
      chk("vec_instret", bus.InstRetW, 64'd9);

      // retire: 10 cycles, 3 of them bubbles
      base = m_cnt;
      for (int i = 0; i < 10; i++) begin
         drive(2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, (i % 3) != 1, 5'd0, 5'd0);
         commit();
      end
      chk("retire_7", bus.InstRetW, base + 64'd7);

      // counter wrap on the narrow instance: 15 retires reach all-ones, the 16th wraps
      bus_s.ValidW = 1'b1;
      repeat (15) begin
         @(posedge clk);
         #1;
      end
      chk("wrap_allones", {60'd0, bus_s.InstRetW}, 64'hF);
      @(posedge clk);
      #1;
      chk("wrap_zero", {60'd0, bus_s.InstRetW}, 64'h0);
      bus_s.ValidW = 1'b0;

      // reset in the middle of a write/retire stream
      for (int i = 0; i < 5; i++) begin
         drive(2'd0, $urandom, 32'd0, 32'd0, 5'(i + 10), 1'b1, 1'b1, 5'd0, 5'd0);
         commit();
      end
      rst = 1'b1;
      drive(2'd0, 32'h77, 32'd0, 32'd0, 5'd9, 1'b1, 1'b1, 5'd9, 5'd12);
      #1;
      chk("midrst_bypass", {32'd0, bus.RD1D}, 64'h77);
      commit();
      rst = 1'b0;
      check_all_zero("midrst");
      chk("midrst_instret", bus.InstRetW, 64'd0);
      drive(2'd1, 32'd0, 32'h1234, 32'd0, 5'd9, 1'b1, 1'b1, 5'd0, 5'd0);
      commit();
      drive(2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 5'd9, 5'd9);
      #1;
      chk("postrst_x9", {32'd0, bus.RD1D}, 64'h1234);
      chk("postrst_instret", bus.InstRetW, 64'd1);

      // randomized run against the reference model
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 39) == 0);
         d = 5'($urandom_range(0, 31));
         v = $urandom;
         drive(2'($urandom_range(0, 3)), v, $urandom, $urandom, d, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)),
               ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)));
         #1;
         chk("rnd_res", {32'd0, bus.ResultW}, {32'd0, m_result()});
         chk("rnd_rd1", {32'd0, bus.RD1D},    {32'd0, m_read(bus.A1D)});
         chk("rnd_rd2", {32'd0, bus.RD2D},    {32'd0, m_read(bus.A2D)});
         commit();
         chk("rnd_instret", bus.InstRetW, m_cnt);
      end
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
